// File: rtl/itch_add_order_path.sv
// ITCH receive front end: frames length-prefixed messages from a TCP
// byte stream and decodes Add Order ('A') messages into parallel fields.
module itch_add_order_path (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  tcp_payload_in,
  input  logic        tcp_byte_valid_in,
  output logic        start_flag,
  output logic [7:0]  payload_out,
  output logic        payload_valid_out,
  output logic        add_order_decoded,
  output logic [63:0] order_ref,
  output logic        buy_sell,
  output logic [31:0] shares,
  output logic [63:0] stock_symbol,
  output logic [31:0] price
);

  typedef enum logic [1:0] {
    LEN_HI,
    LEN_LO,
    BODY
  } hdr_t;

  typedef enum logic {
    IDLE,
    CAPTURE
  } dec_t;

  hdr_t        hst, hst_n;
  logic [15:0] rem, rem_n;
  logic [7:0]  len_hi, len_hi_n;
  logic        at_sof, at_sof_n;
  logic        fwd, sof;
  logic [15:0] len_w;

  dec_t        dst, dst_n;
  logic [5:0]  off, off_n;
  logic        cap;
  logic        done_n, done_q;

  logic [63:0] ref_sh;
  logic        side_sh;
  logic [31:0] shares_sh;
  logic [63:0] stock_sh;
  logic [31:0] price_sh;

  assign len_w = {len_hi, tcp_payload_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      hst    <= LEN_HI;
      rem    <= '0;
      len_hi <= '0;
      at_sof <= 1'b0;
    end else begin
      hst    <= hst_n;
      rem    <= rem_n;
      len_hi <= len_hi_n;
      at_sof <= at_sof_n;
    end
  end

  always_comb begin
    hst_n    = hst;
    rem_n    = rem;
    len_hi_n = len_hi;
    at_sof_n = at_sof;
    fwd      = 1'b0;
    sof      = 1'b0;
    if (tcp_byte_valid_in) begin
      unique case (hst)
        LEN_HI: begin
          len_hi_n = tcp_payload_in;
          hst_n    = LEN_LO;
        end
        LEN_LO: begin
          if (len_w == 16'd0) begin
            hst_n = LEN_HI;
          end else begin
            hst_n    = BODY;
            rem_n    = len_w;
            at_sof_n = 1'b1;
          end
        end
        BODY: begin
          fwd      = 1'b1;
          sof      = at_sof;
          at_sof_n = 1'b0;
          rem_n    = rem - 16'd1;
          if (rem == 16'd1)
            hst_n = LEN_HI;
        end
        default: hst_n = LEN_HI;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      payload_out       <= '0;
      payload_valid_out <= 1'b0;
      start_flag        <= 1'b0;
    end else begin
      payload_valid_out <= fwd;
      start_flag        <= sof;
      if (fwd)
        payload_out <= tcp_payload_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dst    <= IDLE;
      off    <= '0;
      done_q <= 1'b0;
    end else begin
      dst    <= dst_n;
      off    <= off_n;
      done_q <= done_n;
    end
  end

  // A type byte always restarts the decoder, which also drops a
  // truncated message still in CAPTURE.
  always_comb begin
    dst_n  = dst;
    off_n  = off;
    cap    = 1'b0;
    done_n = 1'b0;
    if (payload_valid_out) begin
      if (start_flag) begin
        if (payload_out == 8'h41) begin
          dst_n = CAPTURE;
          off_n = 6'd1;
        end else begin
          dst_n = IDLE;
        end
      end else if (dst == CAPTURE) begin
        cap = 1'b1;
        if (off == 6'd35) begin
          done_n = 1'b1;
          dst_n  = IDLE;
        end else begin
          off_n = off + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_sh    <= '0;
      side_sh   <= 1'b0;
      shares_sh <= '0;
      stock_sh  <= '0;
      price_sh  <= '0;
    end else if (cap) begin
      unique case (1'b1)
        off inside {[6'd11:6'd18]}:
          ref_sh <= {ref_sh[55:0], payload_out};
        off == 6'd19:
          side_sh <= (payload_out == 8'h42);
        off inside {[6'd20:6'd23]}:
          shares_sh <= {shares_sh[23:0], payload_out};
        off inside {[6'd24:6'd31]}:
          stock_sh <= {stock_sh[55:0], payload_out};
        off inside {[6'd32:6'd35]}:
          price_sh <= {price_sh[23:0], payload_out};
        default: ;
      endcase
    end
  end

  // Commit one cycle after the last byte lands in the shadows; the
  // next message's length header guarantees they are still intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_order_decoded <= 1'b0;
      order_ref         <= '0;
      buy_sell          <= 1'b0;
      shares            <= '0;
      stock_symbol      <= '0;
      price             <= '0;
    end else begin
      add_order_decoded <= done_q;
      if (done_q) begin
        order_ref    <= ref_sh;
        buy_sell     <= side_sh;
        shares       <= shares_sh;
        stock_symbol <= stock_sh;
        price        <= price_sh;
      end
    end
  end

endmodule

// File: tb/tb_itch_add_order_path.sv
// Scoreboard bench for itch_add_order_path: byte stream and decoded
// Add Order fields checked against expectations queued at drive time.
module tb_itch_add_order_path;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tcp_payload_in;
  logic        tcp_byte_valid_in;
  logic        start_flag;
  logic [7:0]  payload_out;
  logic        payload_valid_out;
  logic        add_order_decoded;
  logic [63:0] order_ref;
  logic        buy_sell;
  logic [31:0] shares;
  logic [63:0] stock_symbol;
  logic [31:0] price;

  itch_add_order_path dut (
    .clk               (clk),
    .rst               (rst),
    .tcp_payload_in    (tcp_payload_in),
    .tcp_byte_valid_in (tcp_byte_valid_in),
    .start_flag        (start_flag),
    .payload_out       (payload_out),
    .payload_valid_out (payload_valid_out),
    .add_order_decoded (add_order_decoded),
    .order_ref         (order_ref),
    .buy_sell          (buy_sell),
    .shares            (shares),
    .stock_symbol      (stock_symbol),
    .price             (price)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] oref;
    logic        side;
    logic [31:0] shr;
    logic [63:0] stk;
    logic [31:0] prc;
    int          cyc;
  } exp_t;

  exp_t        eq[$];
  logic [8:0]  bq[$];
  int          pc[$];
  exp_t        mdl;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          npulse = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (payload_valid_out) begin
          if (bq.size() == 0) begin
            chk("extra_payload", 1, 0);
          end else begin
            logic [8:0] b;
            b = bq.pop_front();
            chk("payload", {56'd0, payload_out}, {56'd0, b[7:0]});
            chk("sof", {63'd0, start_flag}, {63'd0, b[8]});
          end
        end else begin
          chk("sof_novalid", {63'd0, start_flag}, 64'd0);
        end
        if (add_order_decoded) begin
          npulse++;
          pc.push_back(cyc);
          if (eq.size() == 0) begin
            chk("spurious_pulse", 1, 0);
          end else begin
            mdl = eq.pop_front();
            chk("pulse_cycle", cyc, mdl.cyc);
          end
        end
        chk("order_ref", order_ref, mdl.oref);
        chk("buy_sell", {63'd0, buy_sell}, {63'd0, mdl.side});
        chk("shares", {32'd0, shares}, {32'd0, mdl.shr});
        chk("stock", stock_symbol, mdl.stk);
        chk("price", {32'd0, price}, {32'd0, mdl.prc});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      @(negedge clk);
      tcp_byte_valid_in = 1'b0;
      tcp_payload_in    = 8'hEE;
    end
    @(negedge clk);
    tcp_byte_valid_in = 1'b1;
    tcp_payload_in    = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tcp_byte_valid_in = 1'b0;
      tcp_payload_in    = 8'h00;
    end
  endtask

  function automatic void mk_add(output logic [7:0] q[$],
                                 input exp_t e, input int len);
    q = {};
    q.push_back(8'h41);
    for (int i = 1; i <= 10; i++) q.push_back(8'h00);
    for (int i = 7; i >= 0; i--) q.push_back(e.oref[i*8 +: 8]);
    q.push_back(e.side ? 8'h42 : 8'h53);
    for (int i = 3; i >= 0; i--) q.push_back(e.shr[i*8 +: 8]);
    for (int i = 7; i >= 0; i--) q.push_back(e.stk[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) q.push_back(e.prc[i*8 +: 8]);
    while (q.size() < len) q.push_back(8'h99);
  endfunction

  task automatic send_msg(input logic [7:0] body[$], input bit gaps,
                          input bit is_add, input exp_t e,
                          input int rst_at);
    logic [15:0] len;
    exp_t        x;
    len = 16'(body.size());
    send_byte(len[15:8], gaps);
    send_byte(len[7:0], gaps);
    for (int i = 0; i < body.size(); i++) begin
      if (i == rst_at) begin
        @(negedge clk);
        rst = 1'b1;
        tcp_byte_valid_in = 1'b0;
        bq.delete();
        mdl = '{0, 0, 0, 0, 0, 0};
        @(posedge clk);
        #1;
        chk("rst_pv", {63'd0, payload_valid_out}, 64'd0);
        chk("rst_sof", {63'd0, start_flag}, 64'd0);
        chk("rst_pay", {56'd0, payload_out}, 64'd0);
        chk("rst_pulse", {63'd0, add_order_decoded}, 64'd0);
        chk("rst_ref", order_ref, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      bq.push_back({(i == 0), body[i]});
      send_byte(body[i], gaps);
      if (is_add && i == 35) begin
        x = e;
        x.cyc = cyc + 3;
        eq.push_back(x);
      end
    end
  endtask

  exp_t        m1, m2, m3, none;
  logic [7:0]  q[$];

  initial begin
    m1   = '{64'h1234, 1'b1, 32'd100, 64'h4141504C20202020,
             32'h0016E360, 0};
    m2   = '{64'h5678, 1'b0, 32'd200, 64'h4141504C20202020,
             32'h000F4240, 0};
    m3   = '{64'hDEADBEEFCAFE0001, 1'b1, 32'hFFFFFFFF,
             64'h4D53465420202020, 32'h7FFFFFFF, 0};
    none = '{0, 0, 0, 0, 0, 0};
    mdl  = none;
    rst  = 1'b1;
    tcp_byte_valid_in = 1'b0;
    tcp_payload_in    = 8'h00;
    repeat (3) @(negedge clk);
    chk("init_pv", {63'd0, payload_valid_out}, 64'd0);
    chk("init_price", {32'd0, price}, 64'd0);
    chk("init_stock", stock_symbol, 64'd0);
    rst = 1'b0;
    idle(2);

    mk_add(q, m1, 36);
    send_msg(q, 0, 1, m1, -1);
    idle(4);

    q = {8'h53};
    for (int i = 0; i < 11; i++) q.push_back(8'h30 + 8'(i));
    send_msg(q, 0, 0, none, -1);
    q = {};
    send_msg(q, 0, 0, none, -1);

    mk_add(q, m2, 36);
    send_msg(q, 0, 1, m2, -1);
    mk_add(q, m1, 36);
    send_msg(q, 0, 1, m1, -1);

    mk_add(q, m3, 36);
    q = q[0:19];
    send_msg(q, 0, 0, none, -1);
    mk_add(q, m2, 36);
    send_msg(q, 0, 1, m2, -1);
    idle(3);

    mk_add(q, m1, 36);
    send_msg(q, 1, 1, m1, -1);
    idle(3);

    mk_add(q, m3, 40);
    send_msg(q, 0, 1, m3, -1);
    idle(3);

    mk_add(q, m2, 36);
    send_msg(q, 0, 1, m2, 20);
    idle(2);
    mk_add(q, m1, 36);
    send_msg(q, 0, 1, m1, -1);

    idle(12);
    chk("eq_empty", eq.size(), 0);
    chk("bq_empty", bq.size(), 0);
    chk("pulses", npulse, 7);
    if (pc.size() >= 3)
      chk("b2b_gap", pc[2] - pc[1], 38);
    else
      chk("b2b_gap_missing", pc.size(), 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
